// File: rtl/mem_arbiter_pkg.sv
// Shared types, encodings and helpers for the unified-memory arbiter.
package mem_arbiter_pkg;

  // Default memory access time in cycles.
  localparam int MEM_LAT_DEFAULT = 4;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Port grant encodings.
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_gnt_e;

  // Choose the port to serve. On contention the port that was not served
  // last wins, which gives strict alternation under continuous demand.
  function automatic arb_gnt_e pick_winner(input logic     i_req,
                                           input logic     d_req,
                                           input arb_gnt_e last_grant);
    arb_gnt_e win;
    if (i_req && d_req) begin
      win = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (d_req) begin
      win = GNT_D;
    end else begin
      win = GNT_I;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times the fixed memory access window.
module mem_lat_counter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int            CW       = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  // Next count: load wins over decrement; never underflows.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != ZERO)) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == ZERO);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port fixed-latency memory between the fetch port
// (read-only) and the data port (read/write). One transaction at a time,
// alternating priority on contention, one-cycle valid pulse per response.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        state_d, state_q;
  arb_gnt_e          last_grant_d, last_grant_q;
  arb_gnt_e          win_s;
  logic              mem_enable_d, mem_enable_q;
  logic              mem_wr_d, mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic              i_valid_d, i_valid_q;
  logic [DATA_W-1:0] i_rdata_d, i_rdata_q;
  logic              d_valid_d, d_valid_q;
  logic [DATA_W-1:0] d_rdata_d, d_rdata_q;
  logic              busy_d, busy_q;
  logic              cnt_load_s;
  logic              cnt_dec_s;
  logic              cnt_zero_s;

  mem_lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load_s),
    .dec  (cnt_dec_s),
    .zero (cnt_zero_s)
  );

  // Next-state, grant selection and next values of all registered outputs.
  // last_grant_q doubles as the owner of the transaction in flight.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_s        = pick_winner(i_req, d_req, last_grant_q);
    mem_enable_d = mem_enable_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_valid_d    = 1'b0;
    d_valid_d    = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    cnt_load_s   = 1'b0;
    cnt_dec_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_d      = ST_ACCESS;
          last_grant_d = win_s;
          cnt_load_s   = 1'b1;
          mem_enable_d = 1'b1;
          if (win_s == GNT_D) begin
            mem_wr_d    = d_wr;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_wr_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = {DATA_W{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (cnt_zero_s) begin
          // Last access cycle: mem_rdata is valid now.
          state_d      = ST_RESP;
          mem_enable_d = 1'b0;
          mem_wr_d     = 1'b0;
          if (last_grant_q == GNT_D) begin
            d_valid_d = 1'b1;
            d_rdata_d = mem_wr_q ? {DATA_W{1'b0}} : mem_rdata;
          end else begin
            i_valid_d = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else begin
          cnt_dec_s = 1'b1;
        end
      end

      ST_RESP: begin
        // Requests are ignored here; a held req is seen again in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d      = ST_IDLE;
        mem_enable_d = 1'b0;
        mem_wr_d     = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous abort-on-reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_I;
      mem_enable_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      i_valid_q    <= 1'b0;
      i_rdata_q    <= {DATA_W{1'b0}};
      d_valid_q    <= 1'b0;
      d_rdata_q    <= {DATA_W{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_enable_q <= mem_enable_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_valid_q    <= i_valid_d;
      i_rdata_q    <= i_rdata_d;
      d_valid_q    <= d_valid_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_enable = mem_enable_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign i_valid    = i_valid_q;
  assign i_rdata    = i_rdata_q;
  assign d_valid    = d_valid_q;
  assign d_rdata    = d_rdata_q;
  assign busy       = busy_q;

endmodule
